data_io_cd: RTL
===============

// Module: data_io_cd
// PURPOSE
//  Parametrised SPI slave linking the IO controller (ARM) to a CD-ROM drive core; successor of the PCE-specific CD data_io.
//  Streams command/data words to the ARM and receives status and sector bytes from it. Reports pending events in a status byte.
//  Sits between the SPI_SS2 bus and the CD controller; optional output FIFO decouples the SPI byte rate from the CD core.
// PARAMETERS
//  CMD_BYTES   12    width of cd_command in bytes (returned by CMD_GET)
//  DATA_BYTES  10    width of cd_data in bytes (returned by DATA_GET)
//  FIFO_AW     4     log2 output FIFO depth (depth 16); used only with DATA_IO_CD_FIFO_EN
//  OP_BASE     8'h60 opcode base: STAT_GET=+0 STAT_SEND=+1 CMD_GET=+2 DATA_GET=+3 DATA_SEND=+4 DATAOUT_REQ=+5 ACK=+6
// PORTS
//  clk_sys            in   1             system clock
//  reset              in   1             async active-high reset
//  SPI_SCK/SS2/DI     in   1 each        SPI from ARM; SS2 high = deselected
//  SPI_DO             out  1             SPI to ARM; Z while SS2 high
//  cd_stat            out  16            status word from ARM
//  cd_stat_strobe     out  1             1-cycle pulse, cd_stat updated
//  cd_command         in   8*CMD_BYTES   command block for ARM
//  cd_command_strobe  in   1             new command available
//  cd_data            in   8*DATA_BYTES  data block for ARM
//  cd_data_strobe     in   1             new data available
//  cd_dat_req         in   1             core requests sector data
//  cd_reset_req       in   1             core requests drive reset
//  cd_fifo_halffull   in   1             core's sector FIFO half full
//  cd_data_out        out  8             sector byte to core
//  cd_dm              out  1             data mode bit from DATA_SEND header
//  cd_data_out_valid  out  1             byte valid (pulse without FIFO, level with FIFO)
//  cd_data_out_ready  in   1             core accepts byte (ignored without FIFO)
//  cd_dataout_req     out  1             1-cycle pulse on DATAOUT_REQ byte
// BEHAVIOUR
//  Reset: all outputs 0 (SPI_DO Z); pending flags, overflow, FIFO pointers cleared. SPI-side regs also cleared by SS2 high.
//  SPI side: sample DI on posedge SCK, MSB first; byte 0 = opcode; byte counter saturates at 255.
//  Each byte toggles a flag; clk_sys syncs with 2 flops; event acted on 3 clk_sys cycles after byte end. Min byte period 4 clk_sys.
//  SPI_DO (negedge SCK): CMD_GET byte n>=1 bit b -> cd_command[8*(n-1)+7-b]; DATA_GET same on cd_data; n beyond width -> 0.
//   Other opcodes: status byte, MSB first, repeating.
//  Status = {0, ovf, fifo_full, cd_fifo_halffull, reset_pend, datreq_pend, data_pend, cmd_pend}; fifo_full=ovf=0 without FIFO.
//  Pending flags set on input strobe/level; cleared on 1st payload byte of CMD_GET / DATA_GET / DATA_SEND / ACK respectively.
//   Set and clear in same cycle: set wins (no lost event).
//  STAT_SEND: byte1 -> cd_stat[7:0]; byte2 -> cd_stat[15:8] + strobe. Shorter transfer: no strobe; cd_stat[7:0] updated.
//  DATA_SEND: byte1 header (ignored); byte2 bit7 -> cd_dm; bytes>=3 -> sector data.
//  DATAOUT_REQ: pulse on opcode byte; ACK also clears ovf.
//  SS2 rise mid-transfer: clk_sys byte index resets to 0; partial byte discarded; no strobe for it.
//  Async reset mid-transfer: clk_sys state to reset values; bytes until next SS2 rise are ignored.
// CONFIGURATION
//  DATA_IO_CD_FIFO_EN defined: sector bytes enter 2^FIFO_AW x 8 FIFO.
//   cd_data_out/valid are head/not-empty; pop on valid&ready; first-word latency 1 cycle after write.
//   Write when full: byte dropped, ovf sticky set. Push and pop same cycle when full: pop first, push accepted.
//  Undefined: no FIFO; cd_data_out registered, cd_data_out_valid 1-cycle pulse per byte; ready ignored; status[6:5]=0.
// TESTING
//  SS2 low, send 8'h62 + 12 bytes with cd_command=96'h0B..0A_01 -> DO returns 8'h01, 8'h0A, ..., 8'h0B; cmd_pend clears.
//  cd_command_strobe same cycle as CMD_GET byte1 clear -> cmd_pend stays 1; next STAT_GET reads bit0=1.
//  8'h61,8'h34,8'h12 -> cd_stat=16'h1234, one strobe; SS2 high after 8'h34 -> no strobe.
//  8'h64,hdr,8'h80,8'hAA,8'h55 -> cd_dm=1; core gets AA then 55 (FIFO build: ready held 0 until SS2 high).
//  FIFO build, ready=0, 17 data bytes -> 16 stored; status bit6=1 until 8'h66 received.
//  Reset asserted mid DATA_SEND -> outputs 0, FIFO empty; next full transfer after SS2 cycle behaves normally.

Source files
------------

// File: rtl/data_io_cd.sv
// data_io_cd: SPI slave (SS2) between the IO controller and a CD-ROM core.
// Optional sector FIFO: define DATA_IO_CD_FIFO_EN (depth 2^FIFO_AW).
//
// Ports:
//   clk_sys, reset          system clock, async active-high reset
//   SPI_SCK/SS2/DI/DO       SPI slave; SS2 high = deselected, DO tristated
//   cd_stat, _strobe        16-bit status word written by the ARM
//   cd_command, _strobe     command block read back by CMD_GET
//   cd_data, _strobe        data block read back by DATA_GET
//   cd_dat_req              core wants sector data (level)
//   cd_reset_req            core wants a drive reset (level)
//   cd_fifo_halffull        core's own sector FIFO is half full
//   cd_data_out, _valid     sector byte stream towards the core
//   cd_data_out_ready       core accepts a byte (FIFO build only)
//   cd_dm                   data mode bit from the DATA_SEND header
//   cd_dataout_req          pulse on a DATAOUT_REQ opcode
//
// Opcodes relative to OP_BASE: +0 STAT_GET, +1 STAT_SEND, +2 CMD_GET,
// +3 DATA_GET, +4 DATA_SEND, +5 DATAOUT_REQ, +6 ACK.
// Status byte: {0, ovf, fifo_full, halffull, reset, datreq, data, cmd}.
module data_io_cd #(
    parameter int         CMD_BYTES  = 12,
    parameter int         DATA_BYTES = 10,
    parameter int         FIFO_AW    = 4,
    parameter logic [7:0] OP_BASE    = 8'h60
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    SPI_SCK,
    input  logic                    SPI_SS2,
    input  logic                    SPI_DI,
    output logic                    SPI_DO,
    output logic [15:0]             cd_stat,
    output logic                    cd_stat_strobe,
    input  logic [8*CMD_BYTES-1:0]  cd_command,
    input  logic                    cd_command_strobe,
    input  logic [8*DATA_BYTES-1:0] cd_data,
    input  logic                    cd_data_strobe,
    input  logic                    cd_dat_req,
    input  logic                    cd_reset_req,
    input  logic                    cd_fifo_halffull,
    output logic [7:0]              cd_data_out,
    output logic                    cd_dm,
    output logic                    cd_data_out_valid,
    input  logic                    cd_data_out_ready,
    output logic                    cd_dataout_req
);

    localparam logic [7:0] OP_STAT_SEND   = OP_BASE + 8'd1;
    localparam logic [7:0] OP_CMD_GET     = OP_BASE + 8'd2;
    localparam logic [7:0] OP_DATA_GET    = OP_BASE + 8'd3;
    localparam logic [7:0] OP_DATA_SEND   = OP_BASE + 8'd4;
    localparam logic [7:0] OP_DATAOUT_REQ = OP_BASE + 8'd5;
    localparam logic [7:0] OP_ACK         = OP_BASE + 8'd6;

    // ------------------------------------------------------------
    // SPI clock domain
    // ------------------------------------------------------------
    logic [2:0] bit_cnt;
    logic [6:0] sreg;
    logic [7:0] byte_cnt;
    logic [7:0] spi_op;
    logic [7:0] rx_byte;
    logic       rx_tog;
    logic [7:0] tx_byte;
    logic       do_q;

    always_ff @(posedge SPI_SCK or posedge SPI_SS2) begin
        if (SPI_SS2) begin
            bit_cnt  <= '0;
            sreg     <= '0;
            byte_cnt <= '0;
            spi_op   <= '0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            sreg    <= {sreg[5:0], SPI_DI};
            if (bit_cnt == 3'd7) begin
                if (byte_cnt != 8'hFF)
                    byte_cnt <= byte_cnt + 8'd1;
                if (byte_cnt == 8'd0)
                    spi_op <= {sreg, SPI_DI};
            end
        end
    end

    // Completed byte plus a toggle; rx_byte stays stable for a whole
    // byte time, long enough for clk_sys to pick it up after sync.
    always_ff @(posedge SPI_SCK or posedge reset) begin
        if (reset) begin
            rx_byte <= '0;
            rx_tog  <= 1'b0;
        end else if (!SPI_SS2 && bit_cnt == 3'd7) begin
            rx_byte <= {sreg, SPI_DI};
            rx_tog  <= ~rx_tog;
        end
    end

    logic       ovf;
    logic       fifo_full;
    logic       cmd_pend;
    logic       data_pend;
    logic       datreq_pend;
    logic       reset_pend;
    logic [7:0] stat_byte;

    assign stat_byte = {1'b0, ovf, fifo_full, cd_fifo_halffull,
                        reset_pend, datreq_pend, data_pend, cmd_pend};

    // Byte being shifted out; byte_cnt/bit_cnt already point at the
    // next bit when the falling edge updates DO.
    always_comb begin
        tx_byte = stat_byte;
        if (byte_cnt != 8'd0 && spi_op == OP_CMD_GET) begin
            tx_byte = '0;
            for (int i = 0; i < CMD_BYTES; i++)
                if (byte_cnt == 8'(i + 1))
                    tx_byte = cd_command[8*i +: 8];
        end else if (byte_cnt != 8'd0 && spi_op == OP_DATA_GET) begin
            tx_byte = '0;
            for (int i = 0; i < DATA_BYTES; i++)
                if (byte_cnt == 8'(i + 1))
                    tx_byte = cd_data[8*i +: 8];
        end
    end

    always_ff @(negedge SPI_SCK or posedge SPI_SS2) begin
        if (SPI_SS2)
            do_q <= 1'b0;
        else
            do_q <= tx_byte[3'd7 - bit_cnt];
    end

    assign SPI_DO = (SPI_SS2 || reset) ? 1'bz : do_q;

    // ------------------------------------------------------------
    // clk_sys domain
    // ------------------------------------------------------------
    logic [2:0] tog_s;
    logic [1:0] ss2_s;
    logic       ignore;
    logic [7:0] idx;
    logic [7:0] op;
    logic       ev;
    logic       data_push;
    logic       ovf_clr;

    // ignore blocks bytes of a transfer cut by reset until SS2 rises.
    assign ev        = (tog_s[2] ^ tog_s[1]) && !ignore;
    assign data_push = ev && op == OP_DATA_SEND && idx >= 8'd3;
    assign ovf_clr   = ev && idx == 8'd0 && rx_byte == OP_ACK;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_s          <= '0;
            ss2_s          <= '0;
            ignore         <= 1'b1;
            idx            <= '0;
            op             <= '0;
            cd_stat        <= '0;
            cd_stat_strobe <= 1'b0;
            cd_dm          <= 1'b0;
            cd_dataout_req <= 1'b0;
            cmd_pend       <= 1'b0;
            data_pend      <= 1'b0;
            datreq_pend    <= 1'b0;
            reset_pend     <= 1'b0;
        end else begin
            tog_s          <= {tog_s[1:0], rx_tog};
            ss2_s          <= {ss2_s[0], SPI_SS2};
            cd_stat_strobe <= 1'b0;
            cd_dataout_req <= 1'b0;
            if (ev) begin
                if (idx != 8'hFF)
                    idx <= idx + 8'd1;
                if (idx == 8'd0) begin
                    op <= rx_byte;
                    if (rx_byte == OP_DATAOUT_REQ)
                        cd_dataout_req <= 1'b1;
                end else begin
                    case (op)
                        OP_STAT_SEND: begin
                            if (idx == 8'd1)
                                cd_stat[7:0] <= rx_byte;
                            if (idx == 8'd2) begin
                                cd_stat[15:8]  <= rx_byte;
                                cd_stat_strobe <= 1'b1;
                            end
                        end
                        OP_CMD_GET:
                            if (idx == 8'd1) cmd_pend <= 1'b0;
                        OP_DATA_GET:
                            if (idx == 8'd1) data_pend <= 1'b0;
                        OP_DATA_SEND: begin
                            if (idx == 8'd1)
                                datreq_pend <= 1'b0;
                            if (idx == 8'd2)
                                cd_dm <= rx_byte[7];
                        end
                        OP_ACK:
                            if (idx == 8'd1) reset_pend <= 1'b0;
                        default: ;
                    endcase
                end
            end
            if (ss2_s[1]) begin
                idx    <= '0;
                ignore <= 1'b0;
            end
            // Sets come last so a same-cycle clear never loses an event.
            if (cd_command_strobe) cmd_pend    <= 1'b1;
            if (cd_data_strobe)    data_pend   <= 1'b1;
            if (cd_dat_req)        datreq_pend <= 1'b1;
            if (cd_reset_req)      reset_pend  <= 1'b1;
        end
    end

`ifdef DATA_IO_CD_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]     mem [DEPTH];
    logic [FIFO_AW:0] wptr;
    logic [FIFO_AW:0] rptr;
    logic           empty;
    logic           pop;
    logic           push_ok;

    assign empty     = wptr == rptr;
    assign fifo_full = wptr[FIFO_AW] != rptr[FIFO_AW] &&
                       wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0];
    assign pop       = !empty && cd_data_out_ready;
    // A pop in the same cycle frees the slot being written.
    assign push_ok   = data_push && (!fifo_full || pop);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (ovf_clr)
                ovf <= 1'b0;
            if (data_push && !push_ok)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok)
            mem[wptr[FIFO_AW-1:0]] <= rx_byte;
    end

    assign cd_data_out       = empty ? '0 : mem[rptr[FIFO_AW-1:0]];
    assign cd_data_out_valid = !empty;
`else
    logic unused_ok;

    assign unused_ok = ^{cd_data_out_ready, ovf_clr};
    assign ovf       = 1'b0;
    assign fifo_full = 1'b0;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cd_data_out       <= '0;
            cd_data_out_valid <= 1'b0;
        end else begin
            cd_data_out_valid <= data_push;
            if (data_push)
                cd_data_out <= rx_byte;
        end
    end
`endif

endmodule
